// File: rtl/servo_pkg.sv
// Shared definitions for the wheel-servo PWM path: steering command codes
// (common with the line-follower control stage) and a counter-width helper.
package servo_pkg;

    localparam logic [1:0] DIR_REST  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // Bits needed to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo output: slew-limited width register updated on frame boundaries
// plus the registered frame_us < width comparator.
module servo_pwm_channel
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD_US     = 20000,
    parameter int unsigned PULSE_STOP_US = 1500,
    parameter int unsigned SLEW_US       = 20,
    parameter int unsigned FW            = cnt_w(PERIOD_US)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [FW-1:0] target_i,
    input  logic [FW-1:0] frame_us_i,
    input  logic          boundary_i,
    output logic          servo_o
);

    localparam logic [FW-1:0] STOP_W = FW'(PULSE_STOP_US);
    localparam logic [FW-1:0] SLEW_W = FW'(SLEW_US);

    logic [FW-1:0] width_q, width_d;
    logic [FW-1:0] diff, step;
    logic          up;
    logic          servo_q;

    // Step on the magnitude of the gap so the subtraction never wraps, and
    // clamp to the gap so the width never overshoots its target.
    always_comb begin
        up   = (target_i >= width_q);
        diff = up ? (target_i - width_q) : (width_q - target_i);
        step = ((SLEW_US == 0) || (diff < SLEW_W)) ? diff : SLEW_W;
        width_d = width_q;
        if (boundary_i) begin
            width_d = up ? (width_q + step) : (width_q - step);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            width_q <= STOP_W;
            servo_q <= 1'b0;
        end else begin
            width_q <= width_d;
            servo_q <= (frame_us_i < width_q);
        end
    end

    assign servo_o = servo_q;

endmodule

// File: rtl/servo_pwm_driver.sv
// Two-channel 50 Hz servo PWM driver: us prescaler, frame counter, command
// decode and frame_tick; per-wheel width/slew/compare lives in the channels.
module servo_pwm_driver
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned PERIOD_US      = 20000,
    parameter int unsigned PULSE_STOP_US  = 1500,
    parameter int unsigned PULSE_DELTA_US = 200,
    parameter int unsigned SLEW_US        = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] servo_direction,
    output logic [1:0] servo,
    output logic       frame_tick
);

    localparam int unsigned PRESC = CLK_HZ / 1_000_000;
    localparam int unsigned PW    = cnt_w(PRESC);
    localparam int unsigned FW    = cnt_w(PERIOD_US);

    localparam logic [FW-1:0] STOP_W = FW'(PULSE_STOP_US);
    localparam logic [FW-1:0] FWD_W  = FW'(PULSE_STOP_US + PULSE_DELTA_US);
    localparam logic [FW-1:0] REV_W  = FW'(PULSE_STOP_US - PULSE_DELTA_US);

    logic [PW-1:0] presc_q, presc_d;
    logic [FW-1:0] frame_us_q, frame_us_d;
    logic          frame_tick_q;
    logic          us_tick, boundary;
    logic [1:0][FW-1:0] target;

    assign us_tick  = (presc_q == PW'(PRESC - 1));
    assign boundary = us_tick && (frame_us_q == FW'(PERIOD_US - 1));

    always_comb begin
        presc_d    = us_tick ? '0 : presc_q + 1'b1;
        frame_us_d = frame_us_q;
        if (us_tick) begin
            frame_us_d = boundary ? '0 : frame_us_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            frame_us_q   <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            frame_us_q   <= frame_us_d;
            frame_tick_q <= boundary;
        end
    end

    // Right servo is mirrored, so "left" slows it below stop; reserved acts as rest.
    always_comb begin
        target[0] = STOP_W;
        target[1] = STOP_W;
        case (servo_direction)
            DIR_LEFT:  target[1] = REV_W;
            DIR_RIGHT: target[0] = FWD_W;
            default:   ;
        endcase
    end

    for (genvar i = 0; i < 2; i++) begin : g_ch
        servo_pwm_channel #(
            .PERIOD_US     (PERIOD_US),
            .PULSE_STOP_US (PULSE_STOP_US),
            .SLEW_US       (SLEW_US),
            .FW            (FW)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .target_i   (target[i]),
            .frame_us_i (frame_us_q),
            .boundary_i (boundary),
            .servo_o    (servo[i])
        );
    end

    assign frame_tick = frame_tick_q;

endmodule
